// File: rtl/ccff_pkg.sv
// ccff_pkg: loader state encoding, default chain length and counter sizing helper.
// CCFF_LOADER_PROBE_EN adds the chain-integrity probe states.
package ccff_pkg;
  localparam int DEF_BITSTREAM_SIZE = 29696;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_FINISH
`ifdef CCFF_LOADER_PROBE_EN
    ,
    S_PROBE,
    S_PCHECK
`endif
  } ccff_state_e;
  function automatic int ccff_min_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int DEF_CNT_W = ccff_min_cnt_w(DEF_BITSTREAM_SIZE);
endpackage

// File: rtl/ccff_serializer.sv
// ccff_serializer: word-wide MSB-first shift register with a per-word bit index.
module ccff_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              shift_i,
  output logic              msb_o,
  output logic              last_o
);
  localparam int IW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  logic [WORD_W-1:0] shreg_q;
  logic [IW-1:0]     idx_q;
  assign msb_o  = shreg_q[WORD_W-1];
  assign last_o = idx_q == '0;
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
      idx_q   <= IW'(WORD_W - 1);
    end else if (shift_i) begin
      shreg_q <= shreg_q << 1;
      idx_q   <= idx_q - 1'b1;
    end
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: fetches bitstream words and shifts them MSB-first into the configuration chain.
// Define CCFF_LOADER_PROBE_EN to run a one-hot chain-integrity probe before each load.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int BITSTREAM_SIZE = DEF_BITSTREAM_SIZE,
  parameter int WORD_W         = 32,
  parameter int CNT_W          = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);
  localparam logic [CNT_W-1:0] N = CNT_W'(BITSTREAM_SIZE);
  if (CNT_W < ccff_min_cnt_w(BITSTREAM_SIZE)) begin : g_cnt_w_too_small
    $error("ccff_loader: CNT_W cannot hold BITSTREAM_SIZE");
  end
  ccff_state_e      state_q;
  logic             head_q, shift_en_q, busy_q, done_q, error_q, ser_msb, ser_last;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  assign bit_count_d   = bit_count_q + 1'b1;
  assign word_ready    = state_q == S_FETCH && word_valid;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign bit_count     = bit_count_q;
  ccff_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk_i  (prog_clk),
    .rst_n_i(pReset),
    .load_i (word_ready),
    .data_i (word_data),
    .shift_i(state_q == S_SHIFT),
    .msb_o  (ser_msb),
    .last_o (ser_last)
  );
`ifdef CCFF_LOADER_PROBE_EN
  // Shifts the fabric has already clocked in; the one just issued is still in flight.
  logic [CNT_W-1:0] captured;
  assign captured = bit_count_q - CNT_W'(shift_en_q);
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif
  always_ff @(posedge prog_clk)
    if (!pReset) begin
      state_q     <= S_IDLE;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      bit_count_q <= '0;
    end else begin
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (start) begin
`ifdef CCFF_LOADER_PROBE_EN
            state_q <= S_PROBE;
`else
            state_q <= S_FETCH;
`endif
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            bit_count_q <= '0;
          end
        S_FETCH: if (word_valid) state_q <= S_SHIFT;
        S_SHIFT: begin
          head_q      <= ser_msb;
          shift_en_q  <= 1'b1;
          bit_count_q <= bit_count_d;
          state_q     <= bit_count_d == N ? S_FINISH : ser_last ? S_FETCH : S_SHIFT;
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
`ifdef CCFF_LOADER_PROBE_EN
        S_PROBE:
          if (captured != '0 && ccff_tail) begin
            error_q <= 1'b1;
            state_q <= S_FINISH;
          end else if (bit_count_q != N) begin
            head_q      <= bit_count_q == '0;
            shift_en_q  <= 1'b1;
            bit_count_q <= bit_count_d;
          end else state_q <= S_PCHECK;
        S_PCHECK:
          if (ccff_tail) begin
            bit_count_q <= '0;
            state_q     <= S_FETCH;
          end else begin
            error_q <= 1'b1;
            state_q <= S_FINISH;
          end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
endmodule

// File: doc/ccff_loader.md
Name: ccff_loader

Overview:
- Sequences FPGA configuration-chain programming. Fetches bitstream words over a valid/ready interface, serializes them MSB-first onto ccff_head and drives a per-bit shift enable that gates the fabric programming clock.
- Counts exactly BITSTREAM_SIZE shifts, then reports done.
- Sits between the management-side bitstream source (Wishbone/FIFO) and the fabric's ccff_head/prog_clk/ccff_tail pins.

Parameters:
- BITSTREAM_SIZE, 29696: number of configuration flops in the chain.
- WORD_W, 32: bitstream word width.
- CNT_W, 16: bit-counter width; must hold BITSTREAM_SIZE (elaboration-time assertion).

Ports:
- prog_clk  in  1  programming clock; single clock domain.
- pReset  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load when idle.
- word_valid  in  1  bitstream word available.
- word_data  in  WORD_W  bitstream word; MSB is shifted first.
- word_ready  out  1  word accepted this cycle (valid & ready).
- ccff_head  out  1  serial data to chain head.
- ccff_shift_en  out  1  fabric captures ccff_head on this cycle's prog_clk edge.
- ccff_tail  in  1  chain tail.
- busy  out  1  load in progress.
- done  out  1  sticky; set on completion.
- error  out  1  sticky; set by probe failure (optional feature only).
- bit_count  out  CNT_W  shifts issued in the current load.

Behaviour:
- Reset (pReset=0 at a prog_clk edge):
  - state=IDLE.
  - All outputs 0: word_ready, ccff_head, ccff_shift_en, busy, done, error, bit_count.
  - Reset mid-load aborts immediately; no further shifts issue.
- FSM states IDLE, FETCH, SHIFT, FINISH (plus PROBE and PCHECK with the optional feature).
- IDLE:
  - start=1 → FETCH (or PROBE).
  - Clears done, error and bit_count; sets busy.
  - start while busy is ignored.
- FETCH:
  - word_ready = word_valid (combinational from the state register).
  - On handshake: load the shift register, set the per-word bit index to WORD_W-1, go to SHIFT.
  - No shift_en in FETCH: an inter-word bubble of ≥1 cycle is legal.
- SHIFT:
  - Each cycle drive ccff_head=shreg[MSB] and ccff_shift_en=1 (registered outputs, aligned); then shift left and increment bit_count.
  - bit_count reaching BITSTREAM_SIZE → FINISH. Remaining bits of a partial final word are discarded; no further fetch.
  - Else, word exhausted → FETCH.
- FINISH:
  - Deassert shift_en and ccff_head.
  - done=1 (sticky until next start), busy=0, then IDLE.
- ccff_shift_en is never high for more than BITSTREAM_SIZE cycles per load, plus probe cycles when the optional feature is compiled in.
- Latency: first shift_en ≥2 cycles after start (IDLE→FETCH→SHIFT, with word_valid already high).
- word_valid low in FETCH stalls indefinitely; busy stays 1.

Optional Feature:
- Macro CCFF_LOADER_PROBE_EN.
- Defined: a chain-integrity probe runs before the load.
  - PROBE shifts one '1' followed by BITSTREAM_SIZE-1 '0's (BITSTREAM_SIZE shifts).
  - ccff_tail is sampled the cycle after each shift. Required: 0 after shifts 1..N-1, 1 after shift N.
  - Any mismatch sets error, drives shift_en=0, and goes FINISH with done=1 and no load performed.
  - On pass: reset bit_count, go to FETCH.
  - PCHECK is the one-cycle wait state for the final tail sample.
- Undefined: no PROBE/PCHECK states, ccff_tail unused, error tied 0.

Decomposition:
- Package ccff_pkg holds:
  - state enum encoding;
  - default BITSTREAM_SIZE;
  - helper constant computing the minimum CNT_W.
- One natural sub-module: ccff_serializer (WORD_W shift register + bit index + word-empty flag), reused by FETCH/SHIFT.
- The FSM and counters stay in ccff_loader.

Test Plan:
- BITSTREAM_SIZE=40, WORD_W=8; words 0xA5,0x3C,0xFF,0x00,0x81 with valid always high, start pulse → exactly 40 shift_en cycles; ccff_head sequence equals the words MSB-first; done=1, busy=0, bit_count=40, 5 handshakes.
- BITSTREAM_SIZE=20, WORD_W=8 → third word accepted, only its top 4 bits shifted, no 4th handshake; done=1.
- word_valid deasserted for 10 cycles between words 2 and 3 → shift_en low during the stall, busy=1, final head sequence unchanged.
- pReset=0 asserted after 17 shifts → next edge: all outputs 0, state IDLE; a new start reloads from bit 0 with bit_count restarting at 1.
- start pulsed again mid-load → ignored; total shifts still 40.
- With CCFF_LOADER_PROBE_EN and a 40-flop chain model: probe passes, then the load proceeds (80 shift_en cycles total, error=0). With the chain model shortened to 39 flops → error=1, done=1, no word_ready issued.
